// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the ROM address, and registers the
// returned word into an instruction register offered to decode via valid/ready.
module fetch_unit #(
    parameter logic [17:0] HALT_WORD = 18'h001FF,
    parameter logic [7:0]  RESET_PC  = 8'd0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    output logic [7:0]       address,
    input  logic [17:0]      instr_in,
    input  logic             run_en,
    input  logic             redirect_en,
    input  logic [7:0]       redirect_pc,
    output logic [17:0]      ir,
    output logic [7:0]       ir_pc,
    output logic             ir_valid,
    input  logic             ir_ready,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic {
        S_RUN,
        S_HALT
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       pc_q, pc_d;
    logic [17:0]      ir_q, ir_d;
    logic [7:0]       ir_pc_q, ir_pc_d;
    logic             ir_valid_q, ir_valid_d;
    logic [CNT_W-1:0] fetch_count_q, fetch_count_d;

    logic slot_free;
    logic load;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        ir_pc_d       = ir_pc_q;
        ir_valid_d    = ir_valid_q;
        fetch_count_d = fetch_count_q;

        slot_free = !ir_valid_q || ir_ready;
        load      = (state_q == S_RUN) && run_en && slot_free && !redirect_en;

        if (redirect_en) begin
            // Redirect flushes the IR even when decode is accepting it this cycle.
            pc_d       = redirect_pc;
            ir_valid_d = 1'b0;
            state_d    = S_RUN;
        end else if (load) begin
            ir_d       = instr_in;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            if (fetch_count_q != '1) begin
                fetch_count_d = fetch_count_q + CNT_W'(1);
            end
            if (instr_in == HALT_WORD) begin
                state_d = S_HALT;
            end else begin
                pc_d = pc_q + 8'd1;
            end
        end else if (ir_valid_q && ir_ready) begin
            ir_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_RUN;
            pc_q          <= RESET_PC;
            ir_q          <= '0;
            ir_pc_q       <= '0;
            ir_valid_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            ir_pc_q       <= ir_pc_d;
            ir_valid_q    <= ir_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign address     = pc_q;
    assign ir          = ir_q;
    assign ir_pc       = ir_pc_q;
    assign ir_valid    = ir_valid_q;
    assign halted      = (state_q == S_HALT);
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: ROM array drives instr_in, a cycle-level behavioural model
// of the fetch rules supplies every expected value.
module tb_fetch_unit;

    localparam logic [17:0] HALT = 18'h001FF;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  address;
    logic [17:0] instr_in;
    logic        run_en;
    logic        redirect_en;
    logic [7:0]  redirect_pc;
    logic [17:0] ir;
    logic [7:0]  ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        halted;
    logic [15:0] fetch_count;

    logic [17:0] rom [256];

    // Behavioural model state
    logic [7:0]  m_pc;
    logic [17:0] m_ir;
    logic [7:0]  m_ir_pc;
    logic        m_valid;
    logic        m_halt;
    logic [15:0] m_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [51:0] obs_vec, exp_vec;

    fetch_unit #(
        .HALT_WORD(HALT),
        .RESET_PC (8'd0),
        .CNT_W    (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .instr_in   (instr_in),
        .run_en     (run_en),
        .redirect_en(redirect_en),
        .redirect_pc(redirect_pc),
        .ir         (ir),
        .ir_pc      (ir_pc),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .halted     (halted),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    assign instr_in = rom[address];
    assign obs_vec  = {address, ir, ir_pc, ir_valid, halted, fetch_count};
    assign exp_vec  = {m_pc, m_ir, m_ir_pc, m_valid, m_halt, m_cnt};

    // Advance one clock: apply the fetch rules to the model, then sample after the edge.
    task automatic step();
        logic [17:0] word;
        word = rom[m_pc];
        if (reset) begin
            m_pc = 8'd0; m_ir = 18'd0; m_ir_pc = 8'd0;
            m_valid = 1'b0; m_halt = 1'b0; m_cnt = 16'd0;
        end else if (redirect_en) begin
            m_pc = redirect_pc; m_valid = 1'b0; m_halt = 1'b0;
        end else if (!m_halt && run_en && (!m_valid || ir_ready)) begin
            m_ir = word; m_ir_pc = m_pc; m_valid = 1'b1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (word == HALT) m_halt = 1'b1;
            else m_pc = m_pc + 8'd1;
        end else if (m_valid && ir_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; run_en = 1'b1; redirect_en = 1'b0; redirect_pc = 8'd0; ir_ready = 1'b1;
        step();
        step();
        n_checks++;
        if (obs_vec !== 52'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs_vec, 52'd0);
        end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        n_checks++;
        if (address !== 8'd0) begin
            n_fail++; $display("FAIL seq_addr0: got %h expected 00", address);
        end
        step();
        n_checks++;
        if (ir !== 18'h10840 || ir_pc !== 8'd0 || !ir_valid || address !== 8'd1) begin
            n_fail++; $display("FAIL seq_first: ir=%h ir_pc=%h v=%b addr=%h expected 10840/00/1/01", ir, ir_pc, ir_valid, address);
        end
        step();
        n_checks++;
        if (ir !== 18'h02049 || ir_pc !== 8'd1 || address !== 8'd2 || obs_vec !== exp_vec) begin
            n_fail++; $display("FAIL seq_second: got %h expected %h", obs_vec, exp_vec);
        end
    endtask

    task automatic test_stall();
        ir_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (ir !== 18'h02049 || ir_pc !== 8'd1 || address !== 8'd2 || ir_valid !== 1'b1) begin
                n_fail++; $display("FAIL stall_hold%0d: ir=%h ir_pc=%h addr=%h v=%b", i, ir, ir_pc, address, ir_valid);
            end
        end
        ir_ready = 1'b1;
        step();
        n_checks++;
        if (ir !== 18'h00920 || ir_pc !== 8'd2 || obs_vec !== exp_vec) begin
            n_fail++; $display("FAIL stall_release: got %h expected %h", obs_vec, exp_vec);
        end
        step();
        n_checks++;
        if (ir !== 18'h000CC || fetch_count !== 16'd4) begin
            n_fail++; $display("FAIL seq_count: ir=%h count=%0d expected 000cc/4", ir, fetch_count);
        end
    endtask

    task automatic test_halt();
        step(); step(); step();
        n_checks++;
        if (ir !== HALT || ir_pc !== 8'd6 || halted !== 1'b1 || address !== 8'd6 || ir_valid !== 1'b1) begin
            n_fail++; $display("FAIL halt_entry: ir=%h ir_pc=%h halted=%b addr=%h v=%b", ir, ir_pc, halted, address, ir_valid);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if (ir_valid !== 1'b0 || address !== 8'd6 || fetch_count !== 16'd7 || halted !== 1'b1) begin
                n_fail++; $display("FAIL halt_idle%0d: v=%b addr=%h count=%0d halted=%b", i, ir_valid, address, fetch_count, halted);
            end
        end
        redirect_en = 1'b1; redirect_pc = 8'h80;
        step();
        redirect_en = 1'b0;
        n_checks++;
        if (halted !== 1'b0 || address !== 8'h80 || ir_valid !== 1'b0) begin
            n_fail++; $display("FAIL halt_redirect: halted=%b addr=%h v=%b expected 0/80/0", halted, address, ir_valid);
        end
    endtask

    task automatic test_redirect_flush();
        redirect_en = 1'b1; redirect_pc = 8'h00;
        step();
        redirect_en = 1'b0;
        step(); step(); step();
        n_checks++;
        if (address !== 8'd3 || ir_valid !== 1'b1 || ir_pc !== 8'd2) begin
            n_fail++; $display("FAIL flush_setup: addr=%h v=%b ir_pc=%h", address, ir_valid, ir_pc);
        end
        redirect_en = 1'b1; redirect_pc = 8'h80; ir_ready = 1'b1;
        step();
        redirect_en = 1'b0;
        n_checks++;
        if (ir_valid !== 1'b0 || address !== 8'h80 || fetch_count !== exp_vec[15:0]) begin
            n_fail++; $display("FAIL flush_clear: v=%b addr=%h count=%0d expected 0/80/%0d", ir_valid, address, fetch_count, m_cnt);
        end
        step();
        n_checks++;
        if (ir_pc !== 8'h80 || ir !== rom[8'h80] || ir_valid !== 1'b1) begin
            n_fail++; $display("FAIL flush_target: ir_pc=%h ir=%h v=%b expected 80/%h/1", ir_pc, ir, ir_valid, rom[8'h80]);
        end
    endtask

    task automatic test_wrap_priority();
        redirect_en = 1'b1; redirect_pc = 8'hFF;
        step();
        redirect_en = 1'b0;
        n_checks++;
        if (address !== 8'hFF) begin
            n_fail++; $display("FAIL wrap_ff: got %h expected ff", address);
        end
        step();
        n_checks++;
        if (address !== 8'h00 || ir_pc !== 8'hFF || obs_vec !== exp_vec) begin
            n_fail++; $display("FAIL wrap_00: got %h expected %h", obs_vec, exp_vec);
        end
        rom[8'h40] = HALT;
        redirect_en = 1'b1; redirect_pc = 8'h40;
        step();
        // address now 0x40 presenting HALT; redirect again in the same cycle
        step();
        redirect_en = 1'b0;
        n_checks++;
        if (halted !== 1'b0 || address !== 8'h40 || ir_valid !== 1'b0) begin
            n_fail++; $display("FAIL redirect_vs_halt: halted=%b addr=%h v=%b expected 0/40/0", halted, address, ir_valid);
        end
        step();
        n_checks++;
        if (halted !== 1'b1 || ir !== HALT || ir_pc !== 8'h40) begin
            n_fail++; $display("FAIL halt_after_redirect: halted=%b ir=%h ir_pc=%h", halted, ir, ir_pc);
        end
        rom[8'h40] = 18'h00040;
    endtask

    task automatic test_reset_mid();
        redirect_en = 1'b1; redirect_pc = 8'h10;
        step();
        redirect_en = 1'b0;
        step(); step();
        ir_ready = 1'b0;
        step();
        n_checks++;
        if (ir_valid !== 1'b1 || fetch_count === 16'd0) begin
            n_fail++; $display("FAIL resetmid_setup: v=%b count=%0d", ir_valid, fetch_count);
        end
        reset = 1'b1;
        step();
        reset = 1'b0; ir_ready = 1'b1;
        n_checks++;
        if (address !== 8'd0 || ir_valid !== 1'b0 || ir !== 18'd0 || fetch_count !== 16'd0 || halted !== 1'b0) begin
            n_fail++; $display("FAIL resetmid_state: got %h expected address/ir/v/count/halted all zero", obs_vec);
        end
    endtask

    task automatic test_random();
        for (int a = 0; a < 256; a++) begin
            rom[a] = ($urandom_range(0, 11) == 0) ? HALT : 18'($urandom);
        end
        for (int i = 0; i < 600; i++) begin
            reset       = ($urandom_range(0, 79) == 0);
            run_en      = ($urandom_range(0, 4) != 0);
            ir_ready    = ($urandom_range(0, 2) != 0);
            redirect_en = ($urandom_range(0, 14) == 0);
            redirect_pc = 8'($urandom);
            step();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++; $display("FAIL random_cycle%0d: got %h expected %h", i, obs_vec, exp_vec);
            end
        end
        reset = 1'b0; redirect_en = 1'b0; run_en = 1'b1; ir_ready = 1'b1;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) rom[a] = 18'(a) | 18'h20000;
        rom[0] = 18'h10840; rom[1] = 18'h02049; rom[2] = 18'h00920; rom[3] = 18'h000CC;
        rom[4] = 18'h00011; rom[5] = 18'h00022; rom[6] = HALT;
        rom[8'h40] = 18'h00040;

        test_reset();
        test_sequential();
        test_stall();
        test_halt();
        test_redirect_flush();
        test_wrap_priority();
        test_reset_mid();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
